deglitch_event_unit: RTL and testbench

//  Sits directly downstream of the serial deglitch filter. Consumes its filtered level and the

---
 rtl/deglitch_event_unit.sv | 133 +++++++++++++
 tb/tb_deglitch_event_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/deglitch_event_unit.sv
// Edge-event unit behind the deglitch filter: qualified edge pulses, saturating
// event counter, sticky irq/overflow flags and a hold-off window counted in en_i ticks.
module deglitch_event_unit #(
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned HOLD_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  level_i,
    input  logic [1:0]            cfg_edge_i,
    input  logic [HOLD_WIDTH-1:0] cfg_holdoff_i,
    input  logic                  clr_i,
    input  logic                  ack_i,
    output logic                  level_o,
    output logic                  evt_o,
    output logic                  irq_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  ovf_o,
    output logic                  busy_o
);

    typedef enum logic [0:0] {
        ARMED   = 1'b0,
        HOLDOFF = 1'b1
    } state_e;

    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [HOLD_WIDTH-1:0] HOLD_ZERO = {HOLD_WIDTH{1'b0}};
    localparam logic [HOLD_WIDTH-1:0] HOLD_ONE  = {{(HOLD_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_r;
    logic [HOLD_WIDTH-1:0] timer_r;
    logic                  level_r;
    logic                  evt_r;
    logic                  irq_r;
    logic                  ovf_r;
    logic                  busy_r;
    logic [CNT_WIDTH-1:0]  count_r;

    logic rise_s;
    logic fall_s;
    logic qual_s;
    logic accept_s;
    logic cnt_sat_s;

    // Edge qualification against the registered level; only an armed unit accepts.
    always_comb begin
        rise_s    = level_i & ~level_r;
        fall_s    = ~level_i & level_r;
        qual_s    = (rise_s & cfg_edge_i[0]) | (fall_s & cfg_edge_i[1]);
        accept_s  = (state_r == ARMED) ? qual_s : 1'b0;
        cnt_sat_s = &count_r;
    end

    // Level tracking, event/counter/flag bookkeeping and the hold-off FSM.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ARMED;
            timer_r <= HOLD_ZERO;
            level_r <= 1'b0;
            evt_r   <= 1'b0;
            irq_r   <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b0;
            count_r <= CNT_ZERO;
        end else begin
            level_r <= level_i;
            evt_r   <= accept_s;

            // An accepted event outranks clear and acknowledge on the same cycle.
            if (accept_s) begin
                irq_r <= 1'b1;
                if (clr_i) begin
                    count_r <= CNT_ONE;
                    ovf_r   <= 1'b0;
                end else if (cnt_sat_s) begin
                    ovf_r   <= 1'b1;
                end else begin
                    count_r <= count_r + CNT_ONE;
                end
            end else if (clr_i) begin
                count_r <= CNT_ZERO;
                ovf_r   <= 1'b0;
                irq_r   <= 1'b0;
            end else if (ack_i) begin
                irq_r   <= 1'b0;
            end else begin
                irq_r   <= irq_r;
            end

            case (state_r)
                ARMED: begin
                    if (accept_s && (cfg_holdoff_i != HOLD_ZERO)) begin
                        timer_r <= cfg_holdoff_i;
                        state_r <= HOLDOFF;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                HOLDOFF: begin
                    // Leaving on the tick that brings the timer to zero; a stray zero also exits.
                    if (en_i) begin
                        if (timer_r <= HOLD_ONE) begin
                            timer_r <= HOLD_ZERO;
                            state_r <= ARMED;
                            busy_r  <= 1'b0;
                        end else begin
                            timer_r <= timer_r - HOLD_ONE;
                        end
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ARMED;
                    timer_r <= HOLD_ZERO;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign level_o = level_r;
    assign evt_o   = evt_r;
    assign irq_o   = irq_r;
    assign count_o = count_r;
    assign ovf_o   = ovf_r;
    assign busy_o  = busy_r;

endmodule

// File: tb/tb_deglitch_event_unit.sv
// Self-checking bench for deglitch_event_unit: vector table, directed corner
// sequences and randomized traffic against a behavioural reference model.
module tb_deglitch_event_unit;

    localparam int CW = 4;
    localparam int HW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_ni;
    logic          en_i;
    logic          level_i;
    logic [1:0]    cfg_edge_i;
    logic [HW-1:0] cfg_holdoff_i;
    logic          clr_i;
    logic          ack_i;
    logic          level_o;
    logic          evt_o;
    logic          irq_o;
    logic [CW-1:0] count_o;
    logic          ovf_o;
    logic          busy_o;

    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int m_level, m_evt, m_irq, m_ovf, m_count, m_hold_left;

    deglitch_event_unit #(.CNT_WIDTH(CW), .HOLD_WIDTH(HW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .level_i(level_i),
        .cfg_edge_i(cfg_edge_i), .cfg_holdoff_i(cfg_holdoff_i),
        .clr_i(clr_i), .ack_i(ack_i), .level_o(level_o), .evt_o(evt_o),
        .irq_o(irq_o), .count_o(count_o), .ovf_o(ovf_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          en;
        logic          level;
        logic [1:0]    cfg;
        logic [HW-1:0] hold;
        logic          clr;
        logic          ack;
        int            exp_evt;
        int            exp_count;
        int            exp_irq;
        int            exp_busy;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_level = 0; m_evt = 0; m_irq = 0; m_ovf = 0; m_count = 0; m_hold_left = 0;
    endtask

    // One clock of the event rules, applied to the inputs present at the edge.
    task automatic model_clock();
        int rise, fall, qual, accepted;
        rise = (level_i == 1'b1 && m_level == 0) ? 1 : 0;
        fall = (level_i == 1'b0 && m_level == 1) ? 1 : 0;
        qual = (rise && cfg_edge_i[0]) || (fall && cfg_edge_i[1]) ? 1 : 0;
        accepted = (m_hold_left == 0) && qual ? 1 : 0;
        m_evt = accepted;
        if (accepted) begin
            m_irq = 1;
            if (clr_i) begin
                m_count = 1; m_ovf = 0;
            end else if (m_count == CNT_MAX) begin
                m_ovf = 1;
            end else begin
                m_count = m_count + 1;
            end
            m_hold_left = int'(cfg_holdoff_i);
        end else begin
            if (clr_i) begin
                m_count = 0; m_ovf = 0; m_irq = 0;
            end else if (ack_i) begin
                m_irq = 0;
            end
            if (m_hold_left > 0 && en_i) m_hold_left = m_hold_left - 1;
        end
        m_level = int'(level_i);
    endtask

    task automatic check_model();
        chk("level_o", int'(level_o), m_level);
        chk("evt_o", int'(evt_o), m_evt);
        chk("irq_o", int'(irq_o), m_irq);
        chk("count_o", int'(count_o), m_count);
        chk("ovf_o", int'(ovf_o), m_ovf);
        chk("busy_o", int'(busy_o), (m_hold_left != 0) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        en_i = 1'b1; level_i = 1'b0; cfg_edge_i = 2'b00; cfg_holdoff_i = 8'd0;
        clr_i = 1'b0; ack_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        model_reset();
        #1;
        check_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    vec_t vecs[13];
    int   n_evt, n_busy;

    initial begin
        rst_ni = 1'b1;
        idle_inputs();
        #2;
        do_reset();

        // ---- table-driven vectors ----
        vecs[0]  = '{1'b1, 1'b1, 2'b10, 8'd0, 1'b0, 1'b0, 0, 0, 0, 0};
        vecs[1]  = '{1'b1, 1'b1, 2'b10, 8'd0, 1'b0, 1'b0, 0, 0, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 2'b10, 8'd0, 1'b0, 1'b0, 1, 1, 1, 0};
        vecs[3]  = '{1'b1, 1'b0, 2'b10, 8'd0, 1'b0, 1'b1, 0, 1, 0, 0};
        vecs[4]  = '{1'b0, 1'b1, 2'b11, 8'd2, 1'b0, 1'b0, 1, 2, 1, 1};
        vecs[5]  = '{1'b0, 1'b0, 2'b11, 8'd0, 1'b0, 1'b0, 0, 2, 1, 1};
        vecs[6]  = '{1'b1, 1'b0, 2'b11, 8'd0, 1'b0, 1'b0, 0, 2, 1, 1};
        vecs[7]  = '{1'b1, 1'b1, 2'b11, 8'd0, 1'b1, 1'b0, 0, 0, 0, 0};
        vecs[8]  = '{1'b0, 1'b1, 2'b11, 8'd0, 1'b0, 1'b0, 0, 0, 0, 0};
        vecs[9]  = '{1'b1, 1'b0, 2'b11, 8'd0, 1'b1, 1'b1, 1, 1, 1, 0};
        vecs[10] = '{1'b1, 1'b1, 2'b11, 8'd0, 1'b0, 1'b0, 1, 2, 1, 0};
        vecs[11] = '{1'b1, 1'b1, 2'b00, 8'd0, 1'b0, 1'b0, 0, 2, 1, 0};
        vecs[12] = '{1'b1, 1'b0, 2'b00, 8'd0, 1'b0, 1'b0, 0, 2, 1, 0};
        for (int i = 0; i < 13; i++) begin
            en_i = vecs[i].en; level_i = vecs[i].level; cfg_edge_i = vecs[i].cfg;
            cfg_holdoff_i = vecs[i].hold; clr_i = vecs[i].clr; ack_i = vecs[i].ack;
            tick();
            chk("tbl_evt", int'(evt_o), vecs[i].exp_evt);
            chk("tbl_count", int'(count_o), vecs[i].exp_count);
            chk("tbl_irq", int'(irq_o), vecs[i].exp_irq);
            chk("tbl_busy", int'(busy_o), vecs[i].exp_busy);
        end

        // ---- rising edge at cycle 10, latency one clock ----
        idle_inputs();
        do_reset();
        cfg_edge_i = 2'b01;
        for (int i = 0; i < 10; i++) tick();
        level_i = 1'b1;
        tick();
        chk("t1_evt", int'(evt_o), 1);
        chk("t1_count", int'(count_o), 1);
        chk("t1_irq", int'(irq_o), 1);
        tick();
        chk("t1_evt_drop", int'(evt_o), 0);

        // ---- bounce inside a hold-off window ----
        idle_inputs();
        do_reset();
        cfg_edge_i = 2'b11; cfg_holdoff_i = 8'd3;
        n_evt = 0; n_busy = 0;
        for (int i = 0; i < 10; i++) begin
            en_i = (i % 2 == 0) ? 1'b1 : 1'b0;
            if (i < 4) level_i = ~level_i;
            tick();
            n_evt  += int'(evt_o);
            n_busy += int'(busy_o);
        end
        chk("t2_events", n_evt, 1);
        chk("t2_busy_cycles", n_busy, 6);
        level_i = 1'b1;
        tick();
        chk("t2_count_after", int'(count_o), 2);

        // ---- saturation, overflow and clear ----
        idle_inputs();
        do_reset();
        cfg_edge_i = 2'b11;
        n_evt = 0;
        for (int i = 0; i < 16; i++) begin
            level_i = ~level_i;
            tick();
            n_evt += int'(evt_o);
            if (i == 14) chk("t4_ovf_before", int'(ovf_o), 0);
        end
        chk("t4_events", n_evt, 16);
        chk("t4_count_sat", int'(count_o), CNT_MAX);
        chk("t4_ovf", int'(ovf_o), 1);
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
        chk("t4_count_clr", int'(count_o), 0);
        chk("t4_ovf_clr", int'(ovf_o), 0);

        // ---- reset in the middle of a hold-off ----
        idle_inputs();
        do_reset();
        cfg_edge_i = 2'b01; cfg_holdoff_i = 8'd5; en_i = 1'b0;
        level_i = 1'b1;
        tick();
        tick();
        chk("t6_busy_before", int'(busy_o), 1);
        #2;
        do_reset();
        chk("t6_busy_rst", int'(busy_o), 0);
        chk("t6_count_rst", int'(count_o), 0);
        tick();
        chk("t6_evt_post_rst", int'(evt_o), 1);
        tick();
        chk("t6_evt_once", int'(evt_o), 0);

        // ---- randomized traffic against the model ----
        idle_inputs();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            en_i          = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 9) < 4) level_i = ~level_i;
            cfg_edge_i    = 2'($urandom_range(0, 3));
            cfg_holdoff_i = 8'($urandom_range(0, 4));
            clr_i         = ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0;
            ack_i         = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
